eth_tx_frame_ctrl: RTL and testbench



---
 rtl/eth_tx_pkg.sv | 45 ++++
 rtl/eth_tx_sym_cnt.sv | 52 +++++
 rtl/eth_tx_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_eth_tx_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX framing controller.
// State codes are fixed because the datapath field mux decodes them directly.
package eth_tx_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PREAMBLE  = 4'd1,
      ST_SFD       = 4'd2,
      ST_DEST_ADDR = 4'd3,
      ST_SRC_ADDR  = 4'd4,
      ST_LEN_TYPE  = 4'd5,
      ST_DATA      = 4'd6,
      ST_PAD       = 4'd7,
      ST_FCS       = 4'd8,
      ST_IFG       = 4'd9
   } tx_state_e;

   localparam int unsigned PREAMBLE_BYTES_DEF = 7;
   localparam int unsigned SFD_BYTES          = 1;
   localparam int unsigned MAC_BYTES          = 6;
   localparam int unsigned LEN_TYPE_BYTES     = 2;
   localparam int unsigned FCS_BYTES          = 4;

   localparam int unsigned LEN_W = 11;
   localparam int unsigned PAD_W = 6;

   typedef struct packed {
      logic tx_en;
      logic crc_en;
      logic fifo_rd;
      logic pad_en;
      logic underrun_err;
      logic len_err;
   } tx_ctrl_t;

   // Zero-pad byte count needed to bring a payload up to the minimum frame size.
   function automatic logic [PAD_W-1:0] calc_pad(input logic [LEN_W-1:0] len,
                                                 input int unsigned      min_payload);
      if (32'(len) < min_payload) begin
         return PAD_W'(min_payload - 32'(len));
      end
      return '0;
   endfunction

endpackage

// File: rtl/eth_tx_sym_cnt.sv
// Symbol-within-byte and byte-within-field counter for the TX framing FSM.
// Field_Done marks the last symbol of the last byte of the current field.
module eth_tx_sym_cnt
   import eth_tx_pkg::*;
#(
   parameter int unsigned SPB = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Clr,
   input  logic [LEN_W-1:0] Field_Len,
   output logic [2:0]       Sym_Idx,
   output logic             Byte_Wrap,
   output logic             Field_Done
);

   localparam logic [2:0] SYM_LAST = 3'(SPB - 1);

   logic [2:0]       sym_q, sym_d;
   logic [LEN_W-1:0] byte_q, byte_d;

   assign Byte_Wrap  = (sym_q == SYM_LAST);
   assign Field_Done = Byte_Wrap && (byte_q == (Field_Len - LEN_W'(1)));
   assign Sym_Idx    = sym_q;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      sym_d  = sym_q;
      byte_d = byte_q;
      if (Clr) begin
         sym_d  = '0;
         byte_d = '0;
      end else if (Byte_Wrap) begin
         sym_d  = '0;
         byte_d = byte_q + LEN_W'(1);
      end else begin
         sym_d  = sym_q + 3'd1;
      end
   end

   // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sym_q  <= '0;
         byte_q <= '0;
      end else begin
         sym_q  <= sym_d;
         byte_q <= byte_d;
      end
   end

endmodule

// File: rtl/eth_tx_frame_ctrl.sv
// Ethernet TX framing controller: sequences preamble through IFG for a 2/4/8-bit PHY path,
// with length-driven frame end, zero padding, FIFO underrun abort and IFG enforcement.
module eth_tx_frame_ctrl
   import eth_tx_pkg::*;
#(
   parameter int unsigned DATA_W         = 2,
   parameter int unsigned PREAMBLE_BYTES = PREAMBLE_BYTES_DEF,
   parameter int unsigned MIN_PAYLOAD    = 46,
   parameter int unsigned MAX_PAYLOAD    = 1500,
   parameter int unsigned IFG_BYTES      = 12
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Eth_Pkt_Rdy,
   input  logic [LEN_W-1:0] Pkt_Len,
   input  logic             Fifo_Empty,
   output logic             Fifo_Rd,
   output logic [3:0]       Tx_Ctrl_FSM_State,
   output logic [2:0]       Sym_Idx,
   output logic             Tx_En,
   output logic             Crc_En,
   output logic             Pad_En,
   output logic             Underrun_Err,
   output logic             Len_Err
);

   localparam int unsigned      SPB     = 8 / DATA_W;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

   tx_state_e        state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [PAD_W-1:0] pad_q, pad_d;
   tx_ctrl_t         ctl_q, ctl_d;

   logic [LEN_W-1:0] field_len;
   logic             field_done;
   logic             byte_wrap;
   logic             cnt_clr;
   logic             rd_slot;

   eth_tx_sym_cnt #(
      .SPB (SPB)
   ) u_sym_cnt (
      .Clk        (Clk),
      .Rst        (Rst),
      .Clr        (cnt_clr),
      .Field_Len  (field_len),
      .Sym_Idx    (Sym_Idx),
      .Byte_Wrap  (byte_wrap),
      .Field_Done (field_done)
   );

   always_comb begin
      field_len = '0;
      case (state_q)
         ST_PREAMBLE:  field_len = LEN_W'(PREAMBLE_BYTES);
         ST_SFD:       field_len = LEN_W'(SFD_BYTES);
         ST_DEST_ADDR: field_len = LEN_W'(MAC_BYTES);
         ST_SRC_ADDR:  field_len = LEN_W'(MAC_BYTES);
         ST_LEN_TYPE:  field_len = LEN_W'(LEN_TYPE_BYTES);
         ST_DATA:      field_len = len_q;
         ST_PAD:       field_len = LEN_W'(pad_q);
         ST_FCS:       field_len = LEN_W'(FCS_BYTES);
         ST_IFG:       field_len = LEN_W'(IFG_BYTES);
         default:      field_len = '0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      pad_d         = pad_q;
      ctl_d         = '0;
      rd_slot       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Eth_Pkt_Rdy) begin
               if (Pkt_Len <= MAX_LEN) begin
                  state_d = ST_PREAMBLE;
                  len_d   = Pkt_Len;
                  pad_d   = calc_pad(Pkt_Len, MIN_PAYLOAD);
               end else begin
                  ctl_d.len_err = 1'b1;
               end
            end
         end
         ST_PREAMBLE:  if (field_done) state_d = ST_SFD;
         ST_SFD:       if (field_done) state_d = ST_DEST_ADDR;
         ST_DEST_ADDR: if (field_done) state_d = ST_SRC_ADDR;
         ST_SRC_ADDR:  if (field_done) state_d = ST_LEN_TYPE;
         ST_LEN_TYPE: begin
            if (field_done) begin
               if (len_q != '0)      state_d = ST_DATA;
               else if (pad_q != '0) state_d = ST_PAD;
               else                  state_d = ST_FCS;
            end
         end
         ST_DATA: begin
            if (field_done) begin
               if (pad_q != '0) state_d = ST_PAD;
               else             state_d = ST_FCS;
            end
         end
         ST_PAD:  if (field_done) state_d = ST_FCS;
         ST_FCS:  if (field_done) state_d = ST_IFG;
         ST_IFG:  if (field_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // The next cycle opens a payload byte: FIFO state decides read or abort one cycle early
      // so Fifo_Rd and Underrun_Err can both be registered.
      rd_slot = (state_d == ST_DATA) && ((state_q != ST_DATA) || byte_wrap);
      if (rd_slot && Fifo_Empty) begin
         state_d            = ST_IFG;
         ctl_d.underrun_err = 1'b1;
      end
      ctl_d.fifo_rd = rd_slot && !Fifo_Empty;

      ctl_d.tx_en  = state_d inside {[ST_PREAMBLE:ST_FCS]};
      ctl_d.crc_en = state_d inside {[ST_DEST_ADDR:ST_PAD]};
      ctl_d.pad_en = (state_d == ST_PAD);
   end

   // Counters restart on every field boundary and stay parked while idle.
   assign cnt_clr = (state_d != state_q) || (state_d == ST_IDLE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         pad_q   <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         pad_q   <= pad_d;
         ctl_q   <= ctl_d;
      end
   end

   assign Tx_Ctrl_FSM_State = state_q;
   assign Tx_En             = ctl_q.tx_en;
   assign Crc_En            = ctl_q.crc_en;
   assign Fifo_Rd           = ctl_q.fifo_rd;
   assign Pad_En            = ctl_q.pad_en;
   assign Underrun_Err      = ctl_q.underrun_err;
   assign Len_Err           = ctl_q.len_err;

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Scoreboard bench: three controllers (DATA_W 2, 4, 8) share a clock; stimulus pushes expected
// frame/gap/error/reset records, per-instance monitors measure what the DUT does and compare.
module tb_eth_tx_frame_ctrl;

   typedef enum int {K_FRAME, K_GAP, K_LEN, K_RST} kind_e;

   typedef struct {
      int    inst;
      kind_e kind;
      int    tx;
      int    rd;
      int    gap;
      int    pad;
      int    crc;
      int    ue;
      int    ifg;
      int    low;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic        Clk = 1'b0;
   logic [2:0]  rst, rdy, fifo_empty, fifo_rd, tx_en, crc_en, pad_en, uerr, len_err;
   logic [10:0] pkt_len [3];
   logic [3:0]  state [3];
   logic [2:0]  sym [3];
   int          fifo_cnt [3];

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int find_exp(input int i);
      foreach (sb[k]) if (sb[k].inst == i) return k;
      return -1;
   endfunction

   function automatic int count_exp(input int i);
      int n = 0;
      foreach (sb[k]) if (sb[k].inst == i) n++;
      return n;
   endfunction

   function automatic void push_exp(input int i, input kind_e kd, input int tx, input int rd,
                                    input int gap, input int pad, input int crc, input int ue,
                                    input int ifg, input int low);
      exp_t e;
      e.inst = i; e.kind = kd; e.tx = tx; e.rd = rd; e.gap = gap; e.pad = pad;
      e.crc = crc; e.ue = ue; e.ifg = ifg; e.low = low;
      sb.push_back(e);
   endfunction

   // Payload FIFO model: pops on Fifo_Rd mid-cycle so Fifo_Empty is settled before the next edge.
   always @(negedge Clk) begin
      for (int i = 0; i < 3; i++) begin
         if (fifo_rd[i] === 1'b1 && fifo_cnt[i] > 0) fifo_cnt[i]--;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned DW = (g == 0) ? 2 : (g == 1) ? 4 : 8;

      assign fifo_empty[g] = (fifo_cnt[g] == 0);

      eth_tx_frame_ctrl #(
         .DATA_W (DW)
      ) u_dut (
         .Clk               (Clk),
         .Rst               (rst[g]),
         .Eth_Pkt_Rdy       (rdy[g]),
         .Pkt_Len           (pkt_len[g]),
         .Fifo_Empty        (fifo_empty[g]),
         .Fifo_Rd           (fifo_rd[g]),
         .Tx_Ctrl_FSM_State (state[g]),
         .Sym_Idx           (sym[g]),
         .Tx_En             (tx_en[g]),
         .Crc_En            (crc_en[g]),
         .Pad_En            (pad_en[g]),
         .Underrun_Err      (uerr[g]),
         .Len_Err           (len_err[g])
      );

      logic       rst_seen;
      logic       prev_tx;
      logic [3:0] prev_st;
      bit         frm_open = 1'b0;
      int         t = 0;
      int         tx_c, rd_c, rd_min, rd_max, last_rd, pad_c, crc_c, ue_c, ue_tx, ifg_c;
      int         low_run = 0;
      int         len_w = 0;
      int         len_tx = 0;

      always @(posedge Clk) rst_seen <= rst[g];

      always @(negedge Clk) begin
         int   k;
         exp_t e;
         t++;
         if (rst_seen === 1'b1) begin
            k = find_exp(g);
            if (k >= 0 && sb[k].kind == K_RST) begin
               sb.delete(k);
               check($sformatf("rst%0d_state", g), 32'(state[g]), 0);
               check($sformatf("rst%0d_sym", g), 32'(sym[g]), 0);
               check($sformatf("rst%0d_tx_en", g), 32'(tx_en[g]), 0);
               check($sformatf("rst%0d_crc_en", g), 32'(crc_en[g]), 0);
               check($sformatf("rst%0d_fifo_rd", g), 32'(fifo_rd[g]), 0);
               check($sformatf("rst%0d_pad_en", g), 32'(pad_en[g]), 0);
               check($sformatf("rst%0d_underrun", g), 32'(uerr[g]), 0);
               check($sformatf("rst%0d_len_err", g), 32'(len_err[g]), 0);
            end
            frm_open = 1'b0;
            len_w    = 0;
            low_run  = 0;
            prev_tx  = 1'b0;
            prev_st  = 4'd0;
         end else begin
            if (len_err[g] === 1'b1) begin
               len_w++;
               len_tx = int'(tx_en[g]);
            end else if (len_w > 0) begin
               k = find_exp(g);
               if (k >= 0 && sb[k].kind == K_LEN) begin
                  sb.delete(k);
                  check($sformatf("len%0d_pulse_width", g), len_w, 1);
                  check($sformatf("len%0d_tx_en", g), len_tx, 0);
               end else begin
                  check($sformatf("len%0d_unexpected", g), len_w, 0);
               end
               len_w = 0;
            end

            if (tx_en[g] === 1'b1 && prev_tx === 1'b0) begin
               k = find_exp(g);
               if (k >= 0 && sb[k].kind == K_GAP) begin
                  check($sformatf("gap%0d_tx_low", g), low_run, sb[k].low);
                  sb.delete(k);
               end
               frm_open = 1'b1;
               tx_c = 0; rd_c = 0; rd_min = 1 << 30; rd_max = 0; last_rd = 0;
               pad_c = 0; crc_c = 0; ue_c = 0; ue_tx = 0; ifg_c = 0;
            end
            if (tx_en[g] === 1'b1) low_run = 0;
            else                   low_run++;

            if (frm_open) begin
               tx_c  += int'(tx_en[g]);
               pad_c += int'(pad_en[g]);
               crc_c += int'(crc_en[g]);
               if (state[g] == 4'd9) ifg_c++;
               if (uerr[g] === 1'b1) begin
                  ue_c++;
                  ue_tx = int'(tx_en[g]);
               end
               if (fifo_rd[g] === 1'b1) begin
                  if (rd_c > 0) begin
                     if (t - last_rd < rd_min) rd_min = t - last_rd;
                     if (t - last_rd > rd_max) rd_max = t - last_rd;
                  end
                  last_rd = t;
                  rd_c++;
               end
               if (prev_st == 4'd9 && state[g] == 4'd0) begin
                  frm_open = 1'b0;
                  if (rd_c < 2) rd_min = 0;
                  k = find_exp(g);
                  if (k >= 0 && sb[k].kind == K_FRAME) begin
                     e = sb[k];
                     sb.delete(k);
                     check($sformatf("f%0d_tx_en_cycles", g), tx_c, e.tx);
                     check($sformatf("f%0d_fifo_rd_count", g), rd_c, e.rd);
                     check($sformatf("f%0d_rd_gap_min", g), rd_min, e.gap);
                     check($sformatf("f%0d_rd_gap_max", g), rd_max, e.gap);
                     check($sformatf("f%0d_pad_en_cycles", g), pad_c, e.pad);
                     check($sformatf("f%0d_crc_en_cycles", g), crc_c, e.crc);
                     check($sformatf("f%0d_underrun_pulses", g), ue_c, e.ue);
                     check($sformatf("f%0d_tx_en_at_underrun", g), ue_tx, 0);
                     check($sformatf("f%0d_ifg_cycles", g), ifg_c, e.ifg);
                  end else begin
                     check($sformatf("f%0d_unexpected_frame", g), tx_c, 0);
                  end
               end
            end
            prev_tx = tx_en[g];
            prev_st = state[g];
         end
      end
   end

   task automatic start_frame(input int i, input int len, input int fill);
      @(negedge Clk);
      fifo_cnt[i] = fill;
      pkt_len[i]  = 11'(len);
      rdy[i]      = 1'b1;
      @(negedge Clk);
      rdy[i]      = 1'b0;
   endtask

   task automatic drain(input int i, input int budget);
      int n = 0;
      while (find_exp(i) >= 0 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check($sformatf("drain%0d_pending", i), count_exp(i), 0);
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].inst == i) sb.delete(k);
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      int   n;
      int   rises;
      logic pv;
      rst = 3'b111;
      rdy = 3'b000;
      for (int i = 0; i < 3; i++) begin
         pkt_len[i]  = '0;
         fifo_cnt[i] = 0;
         push_exp(i, K_RST, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      repeat (3) @(negedge Clk);
      rst = 3'b000;
      for (int i = 0; i < 3; i++) drain(i, 10);

      // 2-bit path, minimum payload: no padding
      push_exp(0, K_FRAME, 288, 46, 4, 0, 240, 0, 48, 0);
      start_frame(0, 46, 46);
      drain(0, 8000);

      // 2-bit path, short payload: 36 pad bytes
      push_exp(0, K_FRAME, 288, 10, 4, 144, 240, 0, 48, 0);
      start_frame(0, 10, 10);
      drain(0, 8000);

      // 8-bit path: empty payload, one byte short of minimum, maximum payload
      push_exp(2, K_FRAME, 72, 0, 0, 46, 60, 0, 12, 0);
      start_frame(2, 0, 0);
      drain(2, 8000);
      push_exp(2, K_FRAME, 72, 45, 1, 1, 60, 0, 12, 0);
      start_frame(2, 45, 45);
      drain(2, 8000);
      push_exp(2, K_FRAME, 1526, 1500, 1, 0, 1514, 0, 12, 0);
      start_frame(2, 1500, 1500);
      drain(2, 8000);

      // 4-bit path: FIFO runs dry after 60 of 100 bytes
      push_exp(1, K_FRAME, 164, 60, 2, 0, 148, 1, 24, 0);
      start_frame(1, 100, 60);
      drain(1, 8000);

      // 2-bit path, request held high: back-to-back frames
      push_exp(0, K_FRAME, 360, 64, 4, 0, 312, 0, 48, 0);
      push_exp(0, K_GAP, 0, 0, 0, 0, 0, 0, 0, 49);
      push_exp(0, K_FRAME, 360, 64, 4, 0, 312, 0, 48, 0);
      @(negedge Clk);
      fifo_cnt[0] = 128;
      pkt_len[0]  = 11'd64;
      rdy[0]      = 1'b1;
      rises = 0;
      n     = 0;
      pv    = tx_en[0];
      while (rises < 2 && n < 3000) begin
         @(negedge Clk);
         if (tx_en[0] === 1'b1 && pv === 1'b0) rises++;
         pv = tx_en[0];
         n++;
      end
      rdy[0] = 1'b0;
      drain(0, 8000);

      // Oversize request is rejected
      push_exp(0, K_LEN, 0, 0, 0, 0, 0, 0, 0, 0);
      start_frame(0, 1501, 0);
      drain(0, 50);
      check("len_rejected_state", 32'(state[0]), 0);

      // Reset in the middle of DATA
      start_frame(0, 46, 46);
      n = 0;
      while (state[0] !== 4'd6 && n < 500) begin
         @(negedge Clk);
         n++;
      end
      check("rst_mid_reached_data", 32'(state[0]), 6);
      repeat (7) @(negedge Clk);
      push_exp(0, K_RST, 0, 0, 0, 0, 0, 0, 0, 0);
      rst[0] = 1'b1;
      @(negedge Clk);
      rst[0]      = 1'b0;
      fifo_cnt[0] = 0;
      drain(0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
